// File: rtl/biaspool_shuffler.sv
// biaspool_shuffler
//   Fills a pool of w slots with the w one-hot values, either as a seeded
//   random permutation or as the identity, and streams the result out one
//   slot per cycle.
//
//   Optional feature macro: BIASPOOL_SHUFFLE_EN
//     defined   : INIT -> SHUFFLE (LFSR-driven Fisher-Yates with rejection)
//                 -> FLUSH -> DONE
//     undefined : INIT -> FLUSH -> DONE, identity written, seed ignored
//
//   Ports
//     clock    : single clock, rising edge
//     reset    : asynchronous, active-low
//     start    : request a new fill (sampled only in IDLE)
//     seed     : LFSR seed, captured on the accepted start edge (0 -> 16'hACE1)
//     busy     : high in INIT, SHUFFLE and FLUSH
//     done     : one-cycle pulse in DONE
//     wr_en    : pool write strobe, high only in FLUSH
//     wr_index : one-hot slot being written
//     wr_value : one-hot value written to that slot
//   All outputs are registered.

`ifndef GRID_LEN
`define GRID_LEN 9
`endif

module biaspool_shuffler #(
    parameter int w  = `GRID_LEN,
    parameter int LW = 16
) (
    input  logic          clock,
    input  logic          reset,
    input  logic          start,
    input  logic [LW-1:0] seed,
    output logic          busy,
    output logic          done,
    output logic          wr_en,
    output logic [w-1:0]  wr_index,
    output logic [w-1:0]  wr_value
);

    // Index width for slot counter, shuffle position and candidate.
    localparam int CW = (w > 1) ? $clog2(w) : 1;

    typedef enum logic [2:0] {
        ST_IDLE    = 3'd0,
        ST_INIT    = 3'd1,
        ST_SHUFFLE = 3'd2,
        ST_FLUSH   = 3'd3,
        ST_DONE    = 3'd4
    } state_t;

    state_t        state_r;
    state_t        state_nx_s;
    logic [CW-1:0] k_r;
    logic [CW-1:0] k_nx_s;
    logic          init_to_flush_s;
    logic          shuffle_exit_s;

    logic          busy_nx_s;
    logic          done_nx_s;
    logic          wr_en_nx_s;
    logic [w-1:0]  wr_index_nx_s;
    logic [w-1:0]  wr_value_nx_s;

`ifdef BIASPOOL_SHUFFLE_EN
    // One Galois step, taps 0xB400.
    function automatic logic [LW-1:0] lfsr_step(input logic [LW-1:0] v);
        logic [LW-1:0] r;
        r = v >> 1;
        if (v[0]) begin
            r = r ^ LW'(16'hB400);
        end else begin
            r = r;
        end
        return r;
    endfunction

    logic [w-1:0]  perm_r    [w];
    logic [w-1:0]  perm_nx_s [w];
    logic [LW-1:0] lfsr_r;
    logic [LW-1:0] lfsr_nx_s;
    logic [LW-1:0] lfsr_adv_s;
    logic [CW-1:0] i_r;
    logic [CW-1:0] i_nx_s;
    logic [CW-1:0] cand_s;
    logic          swap_s;

    // Candidate is taken from the freshly advanced LFSR value of this cycle.
    assign lfsr_adv_s      = lfsr_step(lfsr_r);
    assign cand_s          = lfsr_adv_s[CW-1:0];
    assign swap_s          = (state_r == ST_SHUFFLE) && (cand_s <= i_r);
    assign shuffle_exit_s  = swap_s && (i_r == CW'(1));
    // A single-entry pool has nothing to shuffle.
    assign init_to_flush_s = (w == 1);

    // Shuffle datapath: load on accepted start, swap-or-reject in SHUFFLE.
    always_comb begin
        perm_nx_s = perm_r;
        lfsr_nx_s = lfsr_r;
        i_nx_s    = i_r;
        if ((state_r == ST_IDLE) && start) begin
            for (int j = 0; j < w; j++) begin
                perm_nx_s[j] = w'(1'b1) << j;
            end
            i_nx_s    = CW'(w - 1);
            lfsr_nx_s = (seed == {LW{1'b0}}) ? LW'(16'hACE1) : seed;
        end else if (state_r == ST_SHUFFLE) begin
            lfsr_nx_s = lfsr_adv_s;
            if (swap_s) begin
                perm_nx_s[i_r]    = perm_r[cand_s];
                perm_nx_s[cand_s] = perm_r[i_r];
                i_nx_s            = i_r - CW'(1);
            end else begin
                i_nx_s = i_r;
            end
        end else begin
            i_nx_s = i_r;
        end
    end

    // Shuffle state registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            for (int j = 0; j < w; j++) begin
                perm_r[j] <= w'(1'b1) << j;
            end
            lfsr_r <= LW'(16'hACE1);
            i_r    <= {CW{1'b0}};
        end else begin
            perm_r <= perm_nx_s;
            lfsr_r <= lfsr_nx_s;
            i_r    <= i_nx_s;
        end
    end
`else
    logic unused_seed_s;

    assign unused_seed_s   = ^seed;
    assign shuffle_exit_s  = 1'b0;
    assign init_to_flush_s = 1'b1;
`endif

    // State and flush-slot register.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            state_r <= ST_IDLE;
            k_r     <= {CW{1'b0}};
        end else begin
            state_r <= state_nx_s;
            k_r     <= k_nx_s;
        end
    end

    // Next-state and slot counter.
    always_comb begin
        state_nx_s = state_r;
        k_nx_s     = k_r;
        case (state_r)
            ST_IDLE: begin
                if (start) begin
                    state_nx_s = ST_INIT;
                end else begin
                    state_nx_s = ST_IDLE;
                end
            end
            ST_INIT: begin
                k_nx_s = {CW{1'b0}};
                if (init_to_flush_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    state_nx_s = ST_SHUFFLE;
                end
            end
`ifdef BIASPOOL_SHUFFLE_EN
            ST_SHUFFLE: begin
                k_nx_s = {CW{1'b0}};
                if (shuffle_exit_s) begin
                    state_nx_s = ST_FLUSH;
                end else begin
                    state_nx_s = ST_SHUFFLE;
                end
            end
`endif
            ST_FLUSH: begin
                if (k_r == CW'(w - 1)) begin
                    state_nx_s = ST_DONE;
                    k_nx_s     = {CW{1'b0}};
                end else begin
                    state_nx_s = ST_FLUSH;
                    k_nx_s     = k_r + CW'(1);
                end
            end
            ST_DONE: begin
                state_nx_s = ST_IDLE;
                k_nx_s     = {CW{1'b0}};
            end
            default: begin
                state_nx_s = ST_IDLE;
                k_nx_s     = {CW{1'b0}};
            end
        endcase
    end

    // Output values for the coming cycle, derived from the next state so
    // the registered outputs line up with the state they describe.
    always_comb begin
        busy_nx_s = (state_nx_s == ST_INIT) || (state_nx_s == ST_SHUFFLE) ||
                    (state_nx_s == ST_FLUSH);
        done_nx_s = (state_nx_s == ST_DONE);
        if (state_nx_s == ST_FLUSH) begin
            wr_en_nx_s    = 1'b1;
            wr_index_nx_s = w'(1'b1) << k_nx_s;
`ifdef BIASPOOL_SHUFFLE_EN
            wr_value_nx_s = perm_nx_s[k_nx_s];
`else
            wr_value_nx_s = w'(1'b1) << k_nx_s;
`endif
        end else begin
            wr_en_nx_s    = 1'b0;
            wr_index_nx_s = {w{1'b0}};
            wr_value_nx_s = {w{1'b0}};
        end
    end

    // Output registers.
    always_ff @(posedge clock or negedge reset) begin
        if (!reset) begin
            busy     <= 1'b0;
            done     <= 1'b0;
            wr_en    <= 1'b0;
            wr_index <= {w{1'b0}};
            wr_value <= {w{1'b0}};
        end else begin
            busy     <= busy_nx_s;
            done     <= done_nx_s;
            wr_en    <= wr_en_nx_s;
            wr_index <= wr_index_nx_s;
            wr_value <= wr_value_nx_s;
        end
    end

endmodule

// File: tb/tb_biaspool_shuffler.sv
// Bench for biaspool_shuffler: a 9-entry and a 5-entry instance, checked
// against a reference model of the pool fill (array-based Fisher-Yates with
// LFSR candidates and rejection). Adapts to BIASPOOL_SHUFFLE_EN.
module tb_biaspool_shuffler;

`ifdef BIASPOOL_SHUFFLE_EN
    localparam bit SHUF = 1'b1;
`else
    localparam bit SHUF = 1'b0;
`endif

    localparam int W1 = 9;
    localparam int W2 = 5;

    logic          clock = 1'b0;
    logic          reset;
    logic          start;
    logic          sel;
    logic [15:0]   seed;
    logic          start1, start2;
    logic          busy1, done1, wr_en1;
    logic [W1-1:0] wr_index1, wr_value1;
    logic          busy2, done2, wr_en2;
    logic [W2-1:0] wr_index2, wr_value2;

    logic          mon_busy, mon_done, mon_wr_en;
    logic [15:0]   mon_idx, mon_val;

    int errors = 0;
    int checks = 0;
    int exp_v [16];
    logic [15:0] cap [16][16];

    always #5 clock = ~clock;

    assign start1 = start & ~sel;
    assign start2 = start & sel;

    assign mon_busy  = sel ? busy2  : busy1;
    assign mon_done  = sel ? done2  : done1;
    assign mon_wr_en = sel ? wr_en2 : wr_en1;
    assign mon_idx   = sel ? 16'(wr_index2) : 16'(wr_index1);
    assign mon_val   = sel ? 16'(wr_value2) : 16'(wr_value1);

    biaspool_shuffler #(.w(W1), .LW(16)) dut1 (
        .clock(clock), .reset(reset), .start(start1), .seed(seed),
        .busy(busy1), .done(done1), .wr_en(wr_en1),
        .wr_index(wr_index1), .wr_value(wr_value1)
    );

    biaspool_shuffler #(.w(W2), .LW(16)) dut2 (
        .clock(clock), .reset(reset), .start(start2), .seed(seed),
        .busy(busy2), .done(done2), .wr_en(wr_en2),
        .wr_index(wr_index2), .wr_value(wr_value2)
    );

    task automatic check(input string name, input logic [31:0] act, input logic [31:0] exp);
        checks++;
        if (act !== exp) begin
            errors++;
            $display("FAIL %s: got %0h expected %0h (t=%0t)", name, act, exp, $time);
        end
    endtask

    // Reference: slot k receives value 1<<exp_v[k]; cyc = cycles spent shuffling.
    task automatic model_run(input int n, input logic [15:0] sd, output int cyc);
        int p [16];
        int i, c, tmp, mask;
        logic [15:0] l;
        for (int k = 0; k < 16; k++) p[k] = k;
        cyc = 0;
        if (SHUF && n > 1) begin
            l    = (sd == 16'h0000) ? 16'hACE1 : sd;
            mask = (1 << $clog2(n)) - 1;
            i    = n - 1;
            while (i >= 1 && cyc < 100000) begin
                l = (l >> 1) ^ (l[0] ? 16'hB400 : 16'h0000);
                c = int'(l) & mask;
                cyc++;
                if (c <= i) begin
                    tmp = p[i]; p[i] = p[c]; p[c] = tmp;
                    i--;
                end
            end
        end
        for (int k = 0; k < 16; k++) exp_v[k] = p[k];
    endtask

    task automatic check_idle(input string tag);
        check({tag, "_busy"}, {31'b0, mon_busy}, 32'd0);
        check({tag, "_done"}, {31'b0, mon_done}, 32'd0);
        check({tag, "_wr_en"}, {31'b0, mon_wr_en}, 32'd0);
        check({tag, "_wr_index"}, {16'b0, mon_idx}, 32'd0);
        check({tag, "_wr_value"}, {16'b0, mon_val}, 32'd0);
    endtask

    // Full run from a negedge in IDLE; optional reset at flush slot abort_k,
    // optional start held high to exercise the back-to-back restart.
    task automatic run_one(input bit s, input logic [15:0] sd, input int abort_k,
                           input bit hold, input int slot);
        int n, exp_cyc, got_cyc, guard;
        logic [15:0] acc;
        sel = s;
        n = s ? W2 : W1;
        model_run(n, sd, exp_cyc);
        seed  = sd;
        start = 1'b1;
        @(negedge clock);
        if (!hold) start = 1'b0;
        check("init_busy", {31'b0, mon_busy}, 32'd1);
        check("init_wr_en", {31'b0, mon_wr_en}, 32'd0);
        got_cyc = 0;
        @(negedge clock);
        while (mon_busy && !mon_wr_en && !mon_done && got_cyc < 5000) begin
            got_cyc++;
            @(negedge clock);
        end
        check("shuffle_cycles", got_cyc, exp_cyc);
        check("shuffle_min", {31'b0, got_cyc >= (SHUF ? n - 1 : 0)}, 32'd1);
        acc = 16'h0000;
        for (int k = 0; k < n; k++) begin
            check("flush_wr_en", {31'b0, mon_wr_en}, 32'd1);
            check("flush_busy", {31'b0, mon_busy}, 32'd1);
            check("flush_wr_index", {16'b0, mon_idx}, 32'd1 << k);
            check("flush_wr_value", {16'b0, mon_val}, 32'd1 << exp_v[k]);
            acc = acc | mon_val;
            cap[slot][k] = mon_val;
            if (k == abort_k) begin
                #2 reset = 1'b0;
                #1 check_idle("abort_async");
                @(negedge clock);
                check_idle("abort_held");
                reset = 1'b1;
                start = 1'b0;
                return;
            end
            @(negedge clock);
        end
        check("pool_or", {16'b0, acc}, (32'd1 << n) - 32'd1);
        check("done_pulse", {31'b0, mon_done}, 32'd1);
        check("done_busy", {31'b0, mon_busy}, 32'd0);
        check("done_wr_en", {31'b0, mon_wr_en}, 32'd0);
        @(negedge clock);
        check_idle("post_done");
        if (hold) begin
            @(negedge clock);
            start = 1'b0;
            check("hold_reinit_busy", {31'b0, mon_busy}, 32'd1);
            check("hold_reinit_wr_en", {31'b0, mon_wr_en}, 32'd0);
            guard = 0;
            while (!mon_done && guard < 400) begin
                @(negedge clock);
                guard++;
            end
            check("hold_rerun_done", {31'b0, mon_done}, 32'd1);
            @(negedge clock);
            check_idle("hold_post");
        end
    endtask

    typedef struct {
        bit          s;        // 0: 9-entry instance, 1: 5-entry instance
        logic [15:0] sd;
        int          abort_k;  // -1: no reset during the run
        bit          hold;
    } vec_t;

    vec_t vecs [8];

    initial begin
        vecs[0] = '{1'b0, 16'h1234, -1, 1'b0};
        vecs[1] = '{1'b0, 16'h1234, -1, 1'b0};
        vecs[2] = '{1'b0, 16'h0000, -1, 1'b0};
        vecs[3] = '{1'b0, 16'hACE1, -1, 1'b0};
        vecs[4] = '{1'b0, 16'hBEEF,  4, 1'b0};
        vecs[5] = '{1'b0, 16'h7E57, -1, 1'b0};
        vecs[6] = '{1'b0, 16'h5A5A, -1, 1'b1};
        vecs[7] = '{1'b1, 16'h0F0F, -1, 1'b0};

        reset = 1'b0;
        start = 1'b0;
        sel   = 1'b0;
        seed  = 16'h0000;
        #1 check_idle("reset_async");
        @(negedge clock);
        @(negedge clock);
        check_idle("reset_held");
        reset = 1'b1;

        // Start on the very first edge after reset release.
        for (int v = 0; v < 8; v++) begin
            run_one(vecs[v].s, vecs[v].sd, vecs[v].abort_k, vecs[v].hold, v);
        end

        // Same seed twice, and seed 0 against 16'hACE1, give identical writes.
        for (int k = 0; k < W1; k++) begin
            check("repeat_seed", {16'b0, cap[1][k]}, {16'b0, cap[0][k]});
            check("zero_seed", {16'b0, cap[3][k]}, {16'b0, cap[2][k]});
        end

        for (int r = 0; r < 6; r++) begin
            run_one(r[0], 16'($urandom), -1, 1'b0, 8 + r);
        end

        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule

// File: doc/biaspool_shuffler.md
BIASPOOL_SHUFFLER -- requirements
Module: biaspool_shuffler

Interface
REQ-001 SHALL have parameter: w, `GRID_LEN, pool width = number of one-hot entries.
REQ-002 SHALL have parameter: LW, 16, LFSR width.
REQ-003 SHALL have port: clock  input  1  single clock; all state changes on its rising edge.
REQ-004 SHALL have port: reset  input  1  asynchronous, active-low reset.
REQ-005 SHALL have port: start  input  1  request a new pool fill; sampled only in IDLE.
REQ-006 SHALL have port: seed  input  LW  LFSR seed; sampled on the accepted start edge.
REQ-007 SHALL have port: busy  output  1  high in INIT, SHUFFLE and FLUSH.
REQ-008 SHALL have port: done  output  1  one-cycle pulse in DONE.
REQ-009 SHALL have port: wr_en  output  1  pool write strobe, high only in FLUSH.
REQ-010 SHALL have port: wr_index  output  w  one-hot pool slot being written.
REQ-011 SHALL have port: wr_value  output  w  one-hot value written to that slot.

Function
REQ-012 SHALL implement states IDLE, INIT, SHUFFLE, FLUSH, DONE.
REQ-013 SHALL go IDLE->INIT on the edge where start=1; start in any other state is ignored, with no queuing.
REQ-014 In INIT (1 cycle), SHALL load internal perm[k] = 1<<k for k = 0..w-1, i = w-1, and LFSR = seed (16'hACE1 if seed = 0).
REQ-015 In SHUFFLE, SHALL advance the LFSR every cycle (Galois, taps 0xB400) and take cand = LFSR[$clog2(w)-1:0].
REQ-016 If cand <= i, SHALL swap perm[i] and perm[cand] and decrement i; otherwise SHALL reject cand and retry next cycle with i unchanged.
REQ-017 SHALL leave SHUFFLE for FLUSH on the edge that performs the swap with i = 1.
REQ-018 In FLUSH, SHALL spend exactly w cycles, one per k = 0..w-1, each driving wr_en=1, wr_index = 1<<k, wr_value = perm[k], all registered.
REQ-019 SHALL go FLUSH->DONE after k = w-1; DONE lasts 1 cycle with done=1 and busy=0, then returns to IDLE.
REQ-020 Outside FLUSH, wr_en, wr_index and wr_value SHALL be 0.
REQ-021 perm SHALL always hold a permutation of the w one-hot values; OR of all wr_value over one FLUSH = all ones.
REQ-022 An identical seed SHALL produce an identical write sequence.
REQ-023 w = 1 SHALL skip SHUFFLE (INIT->FLUSH).

Reset
REQ-024 reset=0 SHALL immediately force state IDLE, busy=0, done=0, wr_en=0, wr_index=0, wr_value=0, LFSR=16'hACE1, i=0, k=0, independent of clock.
REQ-025 Reset mid-operation SHALL abort the run with no further writes; the next start SHALL begin a full fresh run.
REQ-026 After reset deassertion, start SHALL be accepted from the first clock edge.

Configuration
REQ-027 Macro BIASPOOL_SHUFFLE_EN defined: SHUFFLE state and LFSR SHALL be compiled in per REQ-015..017.
REQ-028 BIASPOOL_SHUFFLE_EN undefined: SHUFFLE and LFSR SHALL be absent, INIT->FLUSH directly, and FLUSH SHALL write the identity (wr_value = wr_index), with seed ignored.

Verification
REQ-029 Macro off, w=9, start pulse at edge 0 -> INIT cycle 1, wr_en high in cycles 2..10 with wr_value=wr_index=1<<(cycle-2), done=1 in cycle 11, busy low in cycle 11.
REQ-030 Macro on, w=9, seed=16'h1234, run twice -> the 9 wr_value words form a permutation (OR = 9'h1FF, no repeats), and both runs are identical.
REQ-031 Macro on, seed=0 vs seed=16'hACE1 -> identical write sequences; cycle count = 2 + SHUFFLE cycles + 9 + 1, with SHUFFLE cycles >= 8.
REQ-032 Drop reset at FLUSH k=4 -> wr_en/wr_index/wr_value/busy go to 0 before the next edge, no writes follow, and a fresh start completes normally.
REQ-033 start held high continuously -> starts mid-run are ignored, and a new INIT follows each DONE->IDLE with exactly one IDLE cycle in between.
REQ-034 Macro on, w=5 (3-bit cand, values 5..7 rejected) -> retry cycles observed, perm remains valid, and done is reached.
